multi_port_memory: RTL and testbench

//  Byte-banked data/instruction memory, 1 write port + READ_PORTS read ports, single clock.

---
 rtl/multi_port_memory_if.sv | 29 ++
 rtl/multi_port_memory.sv | 120 ++++++++++++
 tb/tb_multi_port_memory.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_port_memory_if.sv
// rtl/multi_port_memory_if.sv - store and load port bundle for multi_port_memory
interface multi_port_memory_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_PORTS    = 2
);
  logic                            write_in;
  logic [1:0]                      write_mode_in;
  logic [ADDRESS_WIDTH-1:0]        write_address_in;
  logic [31:0]                     write_data_in;
  logic                            write_misaligned_out;
  logic [READ_PORTS-1:0]           read_en_in;
  logic [3*READ_PORTS-1:0]         read_mode_in;
  logic [ADDRESS_WIDTH*READ_PORTS-1:0] read_address_in;
  logic [32*READ_PORTS-1:0]        read_data_out;
  logic [READ_PORTS-1:0]           read_valid_out;
  logic [READ_PORTS-1:0]           read_misaligned_out;

  modport master (
    output write_in, write_mode_in, write_address_in, write_data_in,
    output read_en_in, read_mode_in, read_address_in,
    input  write_misaligned_out, read_data_out, read_valid_out, read_misaligned_out
  );

  modport slave (
    input  write_in, write_mode_in, write_address_in, write_data_in,
    input  read_en_in, read_mode_in, read_address_in,
    output write_misaligned_out, read_data_out, read_valid_out, read_misaligned_out
  );
endinterface

// File: rtl/multi_port_memory.sv
// rtl/multi_port_memory.sv - byte-banked memory, one store port, READ_PORTS registered load ports
// Optional MEM_BYPASS_EN: same-edge read of a word being stored returns the new lanes (write-first).
module multi_port_memory #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_PORTS    = 2
) (
  input logic                clock_in,
  input logic                reset_n_in,
  multi_port_memory_if.slave bus
);
  localparam int WORD_AW = ADDRESS_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] lo);
    case (mode)
      2'b10:   is_aligned = !lo[0];
      2'b11:   is_aligned = 1'b1;
      default: is_aligned = (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] mode,
                                               input logic [1:0] lo);
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    half_sel = lo[1] ? word[31:16] : word[15:0];
    byte_sel = word[{lo, 3'b000} +: 8];
    case (mode[1:0])
      2'b10:   load_extract = mode[2] ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b11:   load_extract = mode[2] ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: load_extract = word;
    endcase
  endfunction

  // Bank k holds byte lane k of every word (little-endian).
  logic [7:0] bank_mem [4][DEPTH];

  logic [WORD_AW-1:0] wr_idx;
  logic               wr_ok;
  logic [3:0]         wr_mask;
  logic [31:0]        wr_lanes;

  assign wr_idx = bus.write_address_in[ADDRESS_WIDTH-1:2];
  assign wr_ok  = bus.write_in && is_aligned(bus.write_mode_in, bus.write_address_in[1:0]);

  always_comb begin
    wr_mask  = 4'b1111;
    wr_lanes = bus.write_data_in;
    case (bus.write_mode_in)
      2'b10: begin
        wr_mask  = bus.write_address_in[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus.write_data_in[15:0]}};
      end
      2'b11: begin
        wr_mask  = 4'b0001 << bus.write_address_in[1:0];
        wr_lanes = {4{bus.write_data_in[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_n_in && wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) bank_mem[k][wr_idx] <= wr_lanes[8*k +: 8];
      end
    end
  end

  logic [ADDRESS_WIDTH-1:0] rd_addr       [READ_PORTS];
  logic [2:0]               rd_mode       [READ_PORTS];
  logic [31:0]              rd_word       [READ_PORTS];
  logic [31:0]              rd_result     [READ_PORTS];
  logic                     rd_misaligned [READ_PORTS];

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr[p] = bus.read_address_in[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      rd_mode[p] = bus.read_mode_in[p*3 +: 3];
      for (int k = 0; k < 4; k++) begin
        rd_word[p][8*k +: 8] = bank_mem[k][rd_addr[p][ADDRESS_WIDTH-1:2]];
`ifdef MEM_BYPASS_EN
        if (wr_ok && wr_mask[k] && (rd_addr[p][ADDRESS_WIDTH-1:2] == wr_idx))
          rd_word[p][8*k +: 8] = wr_lanes[8*k +: 8];
`endif
      end
      rd_misaligned[p] = !is_aligned(rd_mode[p][1:0], rd_addr[p][1:0]);
      rd_result[p]     = rd_misaligned[p] ? 32'h0 : load_extract(rd_word[p], rd_mode[p], rd_addr[p][1:0]);
    end
  end

  logic [32*READ_PORTS-1:0] data_q;
  logic [READ_PORTS-1:0]    valid_q;
  logic [READ_PORTS-1:0]    misaligned_q;
  logic                     write_misaligned_q;

  // Data and misaligned flag hold between reads; only valid drops when a port idles.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      data_q             <= '0;
      valid_q            <= '0;
      misaligned_q       <= '0;
      write_misaligned_q <= 1'b0;
    end else begin
      write_misaligned_q <= bus.write_in && !is_aligned(bus.write_mode_in, bus.write_address_in[1:0]);
      for (int p = 0; p < READ_PORTS; p++) begin
        valid_q[p] <= bus.read_en_in[p];
        if (bus.read_en_in[p]) begin
          data_q[32*p +: 32] <= rd_result[p];
          misaligned_q[p]    <= rd_misaligned[p];
        end
      end
    end
  end

  assign bus.read_data_out        = data_q;
  assign bus.read_valid_out       = valid_q;
  assign bus.read_misaligned_out  = misaligned_q;
  assign bus.write_misaligned_out = write_misaligned_q;
endmodule

// File: tb/tb_multi_port_memory.sv
// tb/tb_multi_port_memory.sv - randomized and directed bench for multi_port_memory
module tb_multi_port_memory;
  localparam int AW = 8;
  localparam int RP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multi_port_memory_if #(.ADDRESS_WIDTH(AW), .READ_PORTS(RP)) bus ();

  multi_port_memory #(.ADDRESS_WIDTH(AW), .READ_PORTS(RP)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_on    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a flat byte array addressed by byte address.
  logic [7:0]  mm  [256];
  logic [7:0]  nxt [256];
  logic [31:0] exp_data [RP];
  logic [RP-1:0] exp_valid = '0;
  logic [RP-1:0] exp_mis   = '0;
  logic          exp_wmis  = 1'b0;
  int            m_wsz, m_wa, m_rsz, m_ra;
  logic [2:0]    m_mode;
  logic [31:0]   m_v;
  logic [7:0]    m_b;

  function automatic int size_of(input logic [1:0] m);
    return (m == 2'b10) ? 2 : ((m == 2'b11) ? 1 : 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < RP; p++) exp_data[p] = 32'h0;
      exp_valid = '0;
      exp_mis   = '0;
      exp_wmis  = 1'b0;
    end else begin
      nxt   = mm;
      m_wsz = size_of(bus.write_mode_in);
      m_wa  = int'(bus.write_address_in);
      exp_wmis = bus.write_in && (m_wa % m_wsz != 0);
      if (bus.write_in && (m_wa % m_wsz == 0))
        for (int i = 0; i < m_wsz; i++) nxt[m_wa + i] = bus.write_data_in[8*i +: 8];
      for (int p = 0; p < RP; p++) begin
        exp_valid[p] = bus.read_en_in[p];
        if (bus.read_en_in[p]) begin
          m_mode = bus.read_mode_in[3*p +: 3];
          m_ra   = int'(bus.read_address_in[AW*p +: AW]);
          m_rsz  = size_of(m_mode[1:0]);
          if (m_ra % m_rsz != 0) begin
            exp_mis[p]  = 1'b1;
            exp_data[p] = 32'h0;
          end else begin
            exp_mis[p] = 1'b0;
            m_v = 32'h0;
            for (int i = 0; i < m_rsz; i++) begin
`ifdef MEM_BYPASS_EN
              m_b = nxt[m_ra + i];
`else
              m_b = mm[m_ra + i];
`endif
              m_v = m_v | (32'(m_b) << (8*i));
            end
            if (!m_mode[2] && m_rsz < 4 && m_v[8*m_rsz-1])
              m_v = m_v | (32'hFFFF_FFFF << (8*m_rsz));
            exp_data[p] = m_v;
          end
        end
      end
      mm = nxt;
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      for (int p = 0; p < RP; p++) begin
        check($sformatf("cyc port%0d data", p), bus.read_data_out[32*p +: 32], exp_data[p]);
        check($sformatf("cyc port%0d valid", p), {31'b0, bus.read_valid_out[p]}, {31'b0, exp_valid[p]});
        check($sformatf("cyc port%0d misaligned", p), {31'b0, bus.read_misaligned_out[p]}, {31'b0, exp_mis[p]});
      end
      check("cyc write_misaligned", {31'b0, bus.write_misaligned_out}, {31'b0, exp_wmis});
    end
  end

  task automatic set_write(input bit en, input logic [1:0] mode, input logic [7:0] addr, input logic [31:0] data);
    bus.write_in         = en;
    bus.write_mode_in    = mode;
    bus.write_address_in = addr;
    bus.write_data_in    = data;
  endtask

  task automatic set_read(input int p, input bit en, input logic [2:0] mode, input logic [7:0] addr);
    bus.read_en_in[p]              = en;
    bus.read_mode_in[3*p +: 3]     = mode;
    bus.read_address_in[AW*p +: AW] = addr;
  endtask

  task automatic idle();
    set_write(1'b0, 2'b00, 8'h00, 32'h0);
    for (int p = 0; p < RP; p++) set_read(p, 1'b0, 3'b000, 8'h00);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 8'(8'h40 + $urandom_range(0, 15));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    for (int p = 0; p < RP; p++) exp_data[p] = 32'h0;
    idle();
    #1 rst_n = 1'b0;
    #1 check_on = 1'b1;
    #1;
    check("reset valid", {28'b0, bus.read_valid_out}, 32'h0);
    check("reset data0", bus.read_data_out[31:0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 64; w++) begin
      set_write(1'b1, 2'b00, 8'(w*4), $urandom);
      tick();
    end
    idle();
    tick();

    // Signed/unsigned byte load of the same byte on two ports.
    set_write(1'b1, 2'b00, 8'h10, 32'h8081_7F01);
    tick();
    idle();
    set_read(0, 1'b1, 3'b011, 8'h13);
    set_read(1, 1'b1, 3'b111, 8'h13);
    tick();
    check("t2 byte signed", bus.read_data_out[31:0], 32'hFFFF_FF80);
    check("t2 byte unsigned", bus.read_data_out[63:32], 32'h0000_0080);
    check("t2 valid", {28'b0, bus.read_valid_out}, 32'h3);
    check("t2 model pin", exp_data[0], 32'hFFFF_FF80);
    idle();
    tick();

    // Half store over a word.
    set_write(1'b1, 2'b00, 8'h20, 32'h1122_3344);
    tick();
    set_write(1'b1, 2'b10, 8'h22, 32'h0000_BEEF);
    tick();
    idle();
    set_read(0, 1'b1, 3'b000, 8'h20);
    set_read(1, 1'b1, 3'b010, 8'h22);
    set_read(2, 1'b1, 3'b110, 8'h20);
    tick();
    check("t3 word", bus.read_data_out[31:0], 32'hBEEF_3344);
    check("t3 half signed", bus.read_data_out[63:32], 32'hFFFF_BEEF);
    check("t3 half unsigned", bus.read_data_out[95:64], 32'h0000_3344);
    check("t3 model pin", exp_data[1], 32'hFFFF_BEEF);
    idle();
    tick();

    // Misaligned store and load.
    set_write(1'b1, 2'b00, 8'h04, 32'h0123_4567);
    tick();
    set_write(1'b1, 2'b00, 8'h05, 32'hDEAD_BEEF);
    tick();
    check("t4 write misaligned", {31'b0, bus.write_misaligned_out}, 32'h1);
    idle();
    set_read(0, 1'b1, 3'b000, 8'h04);
    set_read(1, 1'b1, 3'b010, 8'h21);
    tick();
    check("t4 write misaligned clear", {31'b0, bus.write_misaligned_out}, 32'h0);
    check("t4 word unchanged", bus.read_data_out[31:0], 32'h0123_4567);
    check("t4 half misaligned data", bus.read_data_out[63:32], 32'h0);
    check("t4 valid", {28'b0, bus.read_valid_out}, 32'h3);
    check("t4 misaligned flags", {28'b0, bus.read_misaligned_out}, 32'h2);
    idle();
    tick();

    // Read during write on the same word.
    set_write(1'b1, 2'b00, 8'h30, 32'h0);
    tick();
    set_write(1'b1, 2'b11, 8'h31, 32'h0000_00AA);
    set_read(0, 1'b1, 3'b000, 8'h30);
    tick();
`ifdef MEM_BYPASS_EN
    check("t5 collide", bus.read_data_out[31:0], 32'h0000_AA00);
`else
    check("t5 collide", bus.read_data_out[31:0], 32'h0000_0000);
`endif
    set_write(1'b0, 2'b00, 8'h00, 32'h0);
    tick();
    check("t5 after", bus.read_data_out[31:0], 32'h0000_AA00);
    idle();
    tick();

    // Reset in the middle of a read; the store during reset must be ignored.
    set_read(0, 1'b1, 3'b000, 8'h30);
    tick();
    check("t1 valid before", {31'b0, bus.read_valid_out[0]}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    set_write(1'b1, 2'b00, 8'h30, 32'hFFFF_FFFF);
    #1;
    check("t1 data0 in reset", bus.read_data_out[31:0], 32'h0);
    check("t1 valid in reset", {28'b0, bus.read_valid_out}, 32'h0);
    check("t1 misaligned in reset", {28'b0, bus.read_misaligned_out}, 32'h0);
    check("t1 wmis in reset", {31'b0, bus.write_misaligned_out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    tick();
    check("t1 valid after release", {28'b0, bus.read_valid_out}, 32'h0);
    tick();
    check("t1 valid idle", {28'b0, bus.read_valid_out}, 32'h0);
    set_read(0, 1'b1, 3'b000, 8'h30);
    tick();
    check("t1 storage kept", bus.read_data_out[31:0], 32'h0000_AA00);
    idle();
    tick();

    // All ports on the top word, back-to-back.
    set_write(1'b1, 2'b00, 8'hFC, 32'hCAFE_F00D);
    tick();
    set_write(1'b0, 2'b00, 8'h00, 32'h0);
    for (int p = 0; p < RP; p++) set_read(p, 1'b1, 3'b000, 8'hFC);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6 valid all", {28'b0, bus.read_valid_out}, 32'hF);
      for (int p = 0; p < RP; p++)
        check($sformatf("t6 port%0d data", p), bus.read_data_out[32*p +: 32], 32'hCAFE_F00D);
    end
    set_read(2, 1'b0, 3'b000, 8'hFC);
    tick();
    check("t6 valid drop2", {28'b0, bus.read_valid_out}, 32'hB);
    idle();
    tick();

    for (int c = 0; c < 1500; c++) begin
      set_write(1'($urandom_range(0, 1)), 2'($urandom), rand_addr(), $urandom);
      for (int p = 0; p < RP; p++)
        set_read(p, ($urandom_range(0, 9) < 7), 3'($urandom), rand_addr());
      tick();
    end
    idle();
    repeat (2) tick();
    check_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
